// File: rtl/sha256_stream_packer_if.sv
// Handshake bundle between the consumer FIFO, the SHA-256 source packer and the padder.
// Every channel transfers on a cycle where its valid and ready are both high; a producer holds valid and payload stable until then.
interface sha256_stream_packer_if #(
    parameter int SRC_IF_DATA_W = 64,
    parameter int SHA_IF_DATA_W = 256,
    parameter int BYTE_W        = 8,
    parameter int MSG_LEN_W     = 32
);
    localparam int SHA_IF_BYTES   = SHA_IF_DATA_W / BYTE_W;
    localparam int SHA_IF_BYTES_W = $clog2(SHA_IF_BYTES);

    logic                      cfg_val;
    logic [MSG_LEN_W-1:0]      cfg_msg_bytes;
    logic                      cfg_rdy;
    logic                      cfg_err;
    logic                      src_data_val;
    logic [SRC_IF_DATA_W-1:0]  src_data;
    logic                      src_rdy;
    logic                      dst_data_val;
    logic [SHA_IF_DATA_W-1:0]  dst_data;
    logic [SHA_IF_BYTES_W-1:0] dst_data_padbytes;
    logic                      dst_data_last;
    logic                      dst_rdy;
    logic                      busy;

    modport slave (
        input  cfg_val, cfg_msg_bytes, src_data_val, src_data, dst_rdy,
        output cfg_rdy, cfg_err, src_rdy, dst_data_val, dst_data,
               dst_data_padbytes, dst_data_last, busy
    );

    modport master (
        output cfg_val, cfg_msg_bytes, src_data_val, src_data, dst_rdy,
        input  cfg_rdy, cfg_err, src_rdy, dst_data_val, dst_data,
               dst_data_padbytes, dst_data_last, busy
    );
endinterface

// File: rtl/sha256_stream_packer.sv
// Packs SRC_IF_DATA_W consumer words into SHA_IF_DATA_W padder beats for one
// configured message; the first word lands in the most significant chunk.
module sha256_stream_packer #(
    parameter int SRC_IF_DATA_W = 64,
    parameter int SHA_IF_DATA_W = 256,
    parameter int BYTE_W        = 8,
    parameter int MSG_LEN_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sha256_stream_packer_if.slave bus,
    output logic [1:0]            dbg_state
);
    localparam int NUM_CHUNKS     = SHA_IF_DATA_W / SRC_IF_DATA_W;
    localparam int SRC_BYTES      = SRC_IF_DATA_W / BYTE_W;
    localparam int SHA_IF_BYTES   = SHA_IF_DATA_W / BYTE_W;
    localparam int SHA_IF_BYTES_W = $clog2(SHA_IF_BYTES);
    localparam int SLOT_W         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int CNT_W          = SHA_IF_BYTES_W + 1;
    localparam int TAKE_W         = $clog2(SRC_BYTES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SEND = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [MSG_LEN_W-1:0]     rem_bytes_q, rem_bytes_d;
    logic [SHA_IF_DATA_W-1:0] buf_q, buf_d;
    logic [SLOT_W-1:0]        slot_q, slot_d;
    logic [CNT_W-1:0]         blk_bytes_q, blk_bytes_d;
    logic                     last_q, last_d;
    logic                     cfg_err_q, cfg_err_d;

    logic [TAKE_W-1:0]        take;
    logic [SRC_IF_DATA_W-1:0] masked_word;
    logic [MSG_LEN_W-1:0]     rem_after;
    logic [CNT_W-1:0]         pad_full;
    logic                     cfg_zero;

    assign cfg_zero = (bus.cfg_msg_bytes == '0);

    // Only the leading message bytes of the final word are valid; its tail is zeroed.
    always_comb begin
        take        = TAKE_W'(SRC_BYTES);
        masked_word = '0;
        if (rem_bytes_q < MSG_LEN_W'(SRC_BYTES)) begin
            take = TAKE_W'(rem_bytes_q);
        end
        for (int b = 0; b < SRC_BYTES; b++) begin
            if (b >= SRC_BYTES - int'(take)) begin
                masked_word[b*BYTE_W +: BYTE_W] = bus.src_data[b*BYTE_W +: BYTE_W];
            end
        end
        rem_after = rem_bytes_q - MSG_LEN_W'(take);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_bytes_q <= '0;
            buf_q       <= '0;
            slot_q      <= '0;
            blk_bytes_q <= '0;
            last_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_bytes_q <= rem_bytes_d;
            buf_q       <= buf_d;
            slot_q      <= slot_d;
            blk_bytes_q <= blk_bytes_d;
            last_q      <= last_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.cfg_val && !cfg_zero) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (bus.src_data_val && ((slot_q == '0) || (rem_after == '0))) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.dst_rdy) begin
                    state_d = last_q ? IDLE : FILL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rem_bytes_d = rem_bytes_q;
        buf_d       = buf_q;
        slot_d      = slot_q;
        blk_bytes_d = blk_bytes_q;
        last_d      = last_q;
        cfg_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cfg_val) begin
                    if (cfg_zero) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        rem_bytes_d = bus.cfg_msg_bytes;
                        buf_d       = '0;
                        slot_d      = SLOT_W'(NUM_CHUNKS - 1);
                        blk_bytes_d = '0;
                        last_d      = 1'b0;
                    end
                end
            end
            FILL: begin
                if (bus.src_data_val) begin
                    buf_d[int'(slot_q)*SRC_IF_DATA_W +: SRC_IF_DATA_W] = masked_word;
                    rem_bytes_d = rem_after;
                    blk_bytes_d = blk_bytes_q + CNT_W'(take);
                    slot_d      = slot_q - 1'b1;
                    last_d      = (rem_after == '0);
                end
            end
            SEND: begin
                // A non-final beat restarts from an empty buffer so unused chunks stay zero.
                if (bus.dst_rdy && !last_q) begin
                    buf_d       = '0;
                    blk_bytes_d = '0;
                    slot_d      = SLOT_W'(NUM_CHUNKS - 1);
                end
            end
            default: ;
        endcase
    end

    assign pad_full = CNT_W'(SHA_IF_BYTES) - blk_bytes_q;

    always_comb begin
        bus.cfg_rdy           = (state_q == IDLE);
        bus.src_rdy           = (state_q == FILL);
        bus.dst_data_val      = (state_q == SEND);
        bus.busy              = (state_q != IDLE);
        bus.cfg_err           = cfg_err_q;
        bus.dst_data          = buf_q;
        bus.dst_data_padbytes = pad_full[SHA_IF_BYTES_W-1:0];
        bus.dst_data_last     = last_q;
        dbg_state             = state_q;
    end
endmodule
